ldl_round_pkt_mux: RTL and testbench

LDL_ROUND_PKT_MUX -- requirements
Module: ldl_round_pkt_mux

---
 rtl/ldl_round_pkg.sv | 20 ++
 rtl/ldl_pipe_reg.sv | 35 +++
 rtl/ldl_round_pkt_mux.sv | 125 ++++++++++++
 tb/tb_ldl_round_pkt_mux.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldl_round_pkg.sv
`default_nettype none
// ============================================================================
// Package : ldl_round_pkg
// Brief   : Shared FSM encoding and beat-counter sizing for the packet mux.
// Rev     : 1.0  initial release
// ============================================================================
package ldl_round_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Counter must be able to hold MAX_BEATS itself, hence the +1.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldl_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module : ldl_pipe_reg
// Brief  : Single-stage valid/ready output register with full-throughput refill.
// Rev    : 1.0  initial release
// ============================================================================
module ldl_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ldl_round_pkt_mux.sv
`default_nettype none
// ============================================================================
// Module : ldl_round_pkt_mux
// Brief  : Packet-granular N:1 mux; locks onto an arbiter-granted source until
//          end of packet or MAX_BEATS truncation.
// Rev    : 1.0  initial release
// ============================================================================
module ldl_round_pkt_mux
    import ldl_round_pkg::*;
#(
    parameter  int BIN_WIDTH  = 3,
    parameter  int COS_WIDTH  = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BEATS  = 256,
    localparam int N          = 1 << BIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              src_valid,
    input  logic [N-1:0]              src_last,
    input  logic [N*DATA_WIDTH-1:0]   src_data,
    input  logic [N*COS_WIDTH-1:0]    src_cos,
    output logic [N-1:0]              src_ready,
    output logic [N-1:0]              arb_req,
    output logic [N*COS_WIDTH-1:0]    arb_cos,
    input  logic                      arb_ack,
    input  logic [BIN_WIDTH-1:0]      arb_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [BIN_WIDTH-1:0]      out_src,
    output logic                      err_trunc
);

    localparam int                 CNT_W    = beat_cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam int                 PAY_W    = DATA_WIDTH + BIN_WIDTH + 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [BIN_WIDTH-1:0]   grant;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   accept;
    logic                   last_beat;
    logic                   trunc;
    logic                   pipe_in_ready;
    logic [PAY_W-1:0]       pipe_in_data;
    logic [PAY_W-1:0]       pipe_out_data;
    logic [DATA_WIDTH-1:0]  data_arr [N];

    generate
        for (genvar i = 0; i < N; i++) begin : g_unpack
            assign data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign arb_cos = src_cos;

    always_comb begin
        state_nxt = state;
        arb_req   = '0;
        src_ready = '0;
        accept    = 1'b0;
        trunc     = 1'b0;
        // The beat landing on the counter's last slot is forced to close the packet.
        last_beat = src_last[grant] || (beat_cnt == LAST_CNT);
        case (state)
            ST_IDLE: begin
                arb_req = src_valid;
                if (arb_ack && src_valid[arb_bin]) begin
                    state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                src_ready[grant] = pipe_in_ready;
                accept           = src_valid[grant] && pipe_in_ready;
                trunc            = accept && !src_last[grant] && (beat_cnt == LAST_CNT);
                if (accept && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            beat_cnt  <= '0;
            err_trunc <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_trunc <= trunc;
            if (state == ST_IDLE && state_nxt == ST_LOCK) begin
                grant    <= arb_bin;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    assign pipe_in_data = {last_beat, grant, data_arr[grant]};

    ldl_pipe_reg #(
        .WIDTH (PAY_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_ready  (pipe_in_ready),
        .in_data   (pipe_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pipe_out_data)
    );

    assign out_last = pipe_out_data[PAY_W-1];
    assign out_src  = pipe_out_data[DATA_WIDTH +: BIN_WIDTH];
    assign out_data = pipe_out_data[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ldl_round_pkt_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_ldl_round_pkt_mux
// Brief  : Directed self-checking bench for the packet mux (MAX_BEATS = 4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ldl_round_pkt_mux;

    localparam int BW = 3;
    localparam int CW = 2;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int N  = 1 << BW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_last;
    logic [N*DW-1:0] src_data;
    logic [N*CW-1:0] src_cos;
    logic [N-1:0]    src_ready;
    logic [N-1:0]    arb_req;
    logic [N*CW-1:0] arb_cos;
    logic            arb_ack;
    logic [BW-1:0]   arb_bin;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic [BW-1:0]   out_src;
    logic            err_trunc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ldl_round_pkt_mux #(
        .BIN_WIDTH  (BW),
        .COS_WIDTH  (CW),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_last  (src_last),
        .src_data  (src_data),
        .src_cos   (src_cos),
        .src_ready (src_ready),
        .arb_req   (arb_req),
        .arb_cos   (arb_cos),
        .arb_ack   (arb_ack),
        .arb_bin   (arb_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .err_trunc (err_trunc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DW-1:0] v);
        src_data[idx*DW +: DW] = v;
    endtask

    task automatic chk_beat(input string tag, input logic [DW-1:0] d, input logic l, input int s);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"},  out_data,  d);
        chk({tag, "_last"},  out_last,  l);
        chk({tag, "_src"},   out_src,   s);
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        src_cos   = '0;
        arb_ack   = 1'b0;
        arb_bin   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_out_src",   out_src,   0);
        chk("rst_err",       err_trunc, 1'b0);
        chk("rst_src_ready", src_ready, 0);
        src_cos = 16'hB1E4;
        #1;
        chk("cos_pass", arb_cos, 16'hB1E4);
        rst = 1'b0;
        tick();

        // 3-beat packet from source 2 while source 0 also requests
        src_valid = 8'h05;
        set_data(2, 32'hD000_0000);
        arb_ack = 1'b1;
        arb_bin = 3'd2;
        #1;
        chk("t1_req_idle",   arb_req,   8'h05);
        chk("t1_rdy_idle",   src_ready, 8'h00);
        tick();
        arb_ack = 1'b0;
        #1;
        chk("t1_req_lock",   arb_req,   8'h00);
        chk("t1_rdy_lock",   src_ready, 8'h04);
        chk("t1_ov_lock",    out_valid, 1'b0);
        tick();
        set_data(2, 32'hD000_0001);
        #1;
        chk_beat("t1_b0", 32'hD000_0000, 1'b0, 2);
        tick();
        set_data(2, 32'hD000_0002);
        src_last = 8'h04;
        #1;
        chk_beat("t1_b1", 32'hD000_0001, 1'b0, 2);
        tick();
        src_valid = 8'h01;
        src_last  = 8'h00;
        #1;
        chk_beat("t1_b2", 32'hD000_0002, 1'b1, 2);
        chk("t1_req_after", arb_req,   8'h01);
        chk("t1_rdy_after", src_ready, 8'h00);
        tick();
        #1;
        chk("t1_drained", out_valid, 1'b0);

        // grant to a non-requesting index is ignored
        arb_ack = 1'b1;
        arb_bin = 3'd3;
        #1;
        chk("t2_rdy0", src_ready, 8'h00);
        tick();
        #1;
        chk("t2_req1", arb_req,   8'h01);
        chk("t2_rdy1", src_ready, 8'h00);
        tick();
        #1;
        chk("t2_req2", arb_req, 8'h01);

        // source 0 with a 4-cycle output stall after the first beat
        arb_bin = 3'd0;
        set_data(0, 32'hE000_0000);
        tick();
        arb_ack = 1'b0;
        #1;
        chk("t3_rdy_lock", src_ready, 8'h01);
        tick();
        out_ready = 1'b0;
        set_data(0, 32'hE000_0001);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_beat("t3_stall", 32'hE000_0000, 1'b0, 0);
            chk("t3_stall_rdy", src_ready, 8'h00);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_resume_data", out_data,  32'hE000_0000);
        chk("t3_resume_rdy",  src_ready, 8'h01);
        tick();
        set_data(0, 32'hE000_0002);
        src_last = 8'h01;
        #1;
        chk_beat("t3_b1", 32'hE000_0001, 1'b0, 0);
        tick();
        src_valid = 8'h00;
        src_last  = 8'h00;
        #1;
        chk_beat("t3_b2", 32'hE000_0002, 1'b1, 0);
        tick();
        #1;
        chk("t3_drained", out_valid, 1'b0);

        // 6-beat packet from source 7 truncated at 4 beats
        src_valid = 8'h80;
        arb_ack   = 1'b1;
        arb_bin   = 3'd7;
        set_data(7, 32'hF000_0001);
        tick();
        arb_ack = 1'b0;
        #1;
        chk("t4_err_c1", err_trunc, 1'b0);
        tick();
        for (int b = 1; b <= 3; b++) begin
            set_data(7, 32'hF000_0001 + b);
            #1;
            chk_beat("t4_pre", 32'hF000_0000 + b, 1'b0, 7);
            chk("t4_err_pre", err_trunc, 1'b0);
            tick();
        end
        set_data(7, 32'hF000_0005);
        arb_ack = 1'b1;
        #1;
        chk_beat("t4_b4", 32'hF000_0004, 1'b1, 7);
        chk("t4_err_pulse", err_trunc, 1'b1);
        chk("t4_req_idle",  arb_req,   8'h80);
        chk("t4_rdy_idle",  src_ready, 8'h00);
        tick();
        arb_ack = 1'b0;
        #1;
        chk("t4_gap_ov",  out_valid, 1'b0);
        chk("t4_err_off", err_trunc, 1'b0);
        tick();
        set_data(7, 32'hF000_0006);
        src_last = 8'h80;
        #1;
        chk_beat("t4_b5", 32'hF000_0005, 1'b0, 7);
        chk("t4_err_b5", err_trunc, 1'b0);
        tick();
        src_valid = 8'h00;
        src_last  = 8'h00;
        #1;
        chk_beat("t4_b6", 32'hF000_0006, 1'b1, 7);
        chk("t4_err_b6", err_trunc, 1'b0);
        tick();

        // reset during beat 2 of a 5-beat packet from source 1
        src_valid = 8'h02;
        arb_ack   = 1'b1;
        arb_bin   = 3'd1;
        set_data(1, 32'hA000_0001);
        tick();
        arb_ack = 1'b0;
        tick();
        set_data(1, 32'hA000_0002);
        rst = 1'b1;
        #1;
        chk("t5_pre_data", out_data, 32'hA000_0001);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_ov",  out_valid, 1'b0);
        chk("t5_req", arb_req,   8'h02);
        chk("t5_rdy", src_ready, 8'h00);
        tick();
        src_valid = 8'h00;
        #1;
        chk("t5_ov2", out_valid, 1'b0);

        // single-beat packets alternating sources 1 and 4
        src_valid = 8'h12;
        src_last  = 8'h12;
        set_data(1, 32'h1111_0001);
        set_data(4, 32'h4444_0004);
        for (int k = 0; k < 4; k++) begin
            arb_ack = 1'b1;
            arb_bin = (k % 2 == 0) ? 3'd1 : 3'd4;
            #1;
            if (k > 0) begin
                if (k % 2 == 0) chk_beat("t6_beat", 32'h4444_0004, 1'b1, 4);
                else            chk_beat("t6_beat", 32'h1111_0001, 1'b1, 1);
            end else begin
                chk("t6_first_ov", out_valid, 1'b0);
            end
            tick();
            arb_ack = 1'b0;
            #1;
            chk("t6_rdy", src_ready, (k % 2 == 0) ? 8'h02 : 8'h10);
            chk("t6_gap", out_valid, 1'b0);
            tick();
        end
        src_valid = 8'h00;
        src_last  = 8'h00;
        #1;
        chk_beat("t6_final", 32'h4444_0004, 1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
